// File: rtl/vector_mem_req_arbiter_if.sv
// Shared request type and the bundle between the load/store units, the arbiter and memory.
// Latency: n/a (type and wiring only).
// Backpressure: req_grant toward the units, mem_req_grant from memory; responses are never stalled.
//
// Ports (interface members):
//   req_in[NUM_PORTS]  : per-unit requests, qualified by .vld
//   req_grant          : one-hot acceptance pulse per unit
//   rsp_out[NUM_PORTS] : routed memory responses, single-cycle .vld
//   mem_req            : request toward memory, qualified by .vld
//   mem_req_grant      : memory accepts mem_req this cycle
//   mem_rsp            : memory response, qualified by .vld
//   rsp_err            : sticky dropped/unroutable response flag

package vector_mem_req_arbiter_pkg;
    localparam int CORE_ID_W = 8;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic                 vld;
        logic [CORE_ID_W-1:0] core_id;
        logic                 we;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
    } request_t;
endpackage

interface vector_mem_req_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    import vector_mem_req_arbiter_pkg::*;

    request_t               req_in  [NUM_PORTS];
    logic [NUM_PORTS-1:0]   req_grant;
    request_t               rsp_out [NUM_PORTS];
    request_t               mem_req;
    logic                   mem_req_grant;
    request_t               mem_rsp;
    logic                   rsp_err;

    // Arbiter side.
    modport slave (
        input  req_in,
        input  mem_req_grant,
        input  mem_rsp,
        output req_grant,
        output rsp_out,
        output mem_req,
        output rsp_err
    );

    // Load/store units plus memory, as seen from outside the arbiter.
    modport master (
        output req_in,
        output mem_req_grant,
        output mem_rsp,
        input  req_grant,
        input  rsp_out,
        input  mem_req,
        input  rsp_err
    );
endinterface

// File: rtl/vector_mem_req_arbiter.sv
// Round-robin arbiter of per-unit requests onto one memory port, with response routing by core_id.
// Latency: grant in cycle N -> mem_req in N+1; mem_rsp in N -> rsp_out in N+1.
// Backpressure: no grants while mem_req is held unaccepted or a unit is at MAX_OUTSTANDING.
//
// Ports:
//   clk_i    : clock, rising edge
//   reset_ni : synchronous active-low reset
//   arb_io   : vector_mem_req_arbiter_if.slave (req_in/req_grant, mem_req/mem_req_grant,
//              mem_rsp/rsp_out, rsp_err)

module vector_mem_req_arbiter
    import vector_mem_req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int BASE_CORE_ID    = 8,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    vector_mem_req_arbiter_if.slave     arb_io
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [CNT_W-1:0]     CNT_MAX      = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CORE_ID_W-1:0] BASE_ID      = CORE_ID_W'(BASE_CORE_ID);
    localparam logic [CORE_ID_W-1:0] NUM_PORTS_ID = CORE_ID_W'(NUM_PORTS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    request_t           mem_req_q, mem_req_d;
    request_t           rsp_out_q [NUM_PORTS];
    request_t           rsp_out_d [NUM_PORTS];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   outstanding_q [NUM_PORTS];
    logic [CNT_W-1:0]   outstanding_d [NUM_PORTS];
    logic               rsp_err_q, rsp_err_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                   slot_free;
    logic [NUM_PORTS-1:0]   eligible;
    logic                   win_vld;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       cand;

    // The output register can take a new request if it is empty or being drained this cycle.
    assign slot_free = !mem_req_q.vld || arb_io.mem_req_grant;

    // Reset gates eligibility so req_grant stays low while reset is asserted.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = reset_ni
                        && arb_io.req_in[i].vld
                        && (outstanding_q[i] < CNT_MAX)
                        && slot_free;
        end
    end

    // Search rr_ptr, rr_ptr+1, ... modulo NUM_PORTS; the first eligible port wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!win_vld && eligible[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        arb_io.req_grant = '0;
        if (win_vld) begin
            arb_io.req_grant[win_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response decode
    // ------------------------------------------------------------------
    logic [CORE_ID_W-1:0]   rsp_idx;
    logic [PTR_W-1:0]       rsp_port;
    logic                   rsp_in_range;
    logic                   rsp_hit;

    // Unsigned subtraction: core_ids below the base wrap to large values and fail the range check.
    assign rsp_idx      = arb_io.mem_rsp.core_id - BASE_ID;
    assign rsp_in_range = rsp_idx < NUM_PORTS_ID;
    assign rsp_port     = rsp_idx[PTR_W-1:0];
    // A response for a port with nothing outstanding cannot be legitimate, so it is dropped.
    assign rsp_hit      = arb_io.mem_rsp.vld
                        && rsp_in_range
                        && (outstanding_q[rsp_port] != '0);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        if (win_vld) begin
            mem_req_d = arb_io.req_in[win_idx];
        end else if (arb_io.mem_req_grant) begin
            mem_req_d = '0;
        end else begin
            mem_req_d = mem_req_q;
        end
    end

    assign rr_ptr_d = win_vld ? PTR_W'((int'(win_idx) + 1) % NUM_PORTS) : rr_ptr_q;

    // Increment can only happen below CNT_MAX and decrement only above zero (both enforced by
    // eligible/rsp_hit), so the counters never wrap. A grant and a response on the same port
    // in one cycle cancel out.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            logic inc;
            logic dec;
            inc = win_vld && (win_idx == PTR_W'(i));
            dec = rsp_hit && (rsp_port == PTR_W'(i));
            outstanding_d[i] = outstanding_q[i];
            if (inc && !dec) begin
                outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
            end
        end
    end

    // rsp_out entries are one-cycle pulses: anything not freshly routed is cleared.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rsp_out_d[i] = (rsp_hit && (rsp_port == PTR_W'(i))) ? arb_io.mem_rsp : '0;
        end
    end

    assign rsp_err_d = rsp_err_q | (arb_io.mem_rsp.vld & ~rsp_hit);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            mem_req_q <= '0;
            rr_ptr_q  <= '0;
            rsp_err_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rsp_out_q[i]     <= '0;
                outstanding_q[i] <= '0;
            end
        end else begin
            mem_req_q <= mem_req_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_err_q <= rsp_err_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rsp_out_q[i]     <= rsp_out_d[i];
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign arb_io.mem_req = mem_req_q;
    assign arb_io.rsp_err = rsp_err_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rsp_out
        assign arb_io.rsp_out[g] = rsp_out_q[g];
    end

endmodule
